// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with registered sync/RGB output stage
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   pix_en       pixel-rate enable; counters and output stage advance only when high
//   pixel_on     lit/unlit result from display logic for the current pixel_x/pixel_y
//   pixel_x      horizontal count, 0..H_TOTAL-1
//   pixel_y      vertical count, 0..V_TOTAL-1
//   video_on     current coordinates lie inside the visible area (combinational)
//   frame_start  pix_en cycle presenting (0,0)
//   hsync/vsync  registered sync outputs, aligned with rgb
//   rgb          registered RGB444 colour, one pix_en cycle behind the coordinates
//
// Parameter limits: H_TOTAL <= 2048 and V_TOTAL <= 1024 so the counters cannot overflow.
module vga_timing_gen #(
    parameter int          H_VISIBLE = 800,
    parameter int          H_FRONT   = 56,
    parameter int          H_SYNC    = 120,
    parameter int          H_BACK    = 64,
    parameter int          V_VISIBLE = 600,
    parameter int          V_FRONT   = 37,
    parameter int          V_SYNC    = 6,
    parameter int          V_BACK    = 23,
    parameter logic        SYNC_POL  = 1'b1,
    parameter logic [11:0] FG_COLOR  = 12'hFFF,
    parameter logic [11:0] BG_COLOR  = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        pixel_on,
    output logic [10:0] pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb
);

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    logic        h_last;
    logic        v_last;
    logic        hsync_c;
    logic        vsync_c;
    logic [11:0] rgb_c;

    // Comparisons are done in 32-bit int so sync end bounds up to the
    // counter limits never truncate.
    assign h_last      = (int'(pixel_x) == H_TOTAL - 1);
    assign v_last      = (int'(pixel_y) == V_TOTAL - 1);
    assign video_on    = (int'(pixel_x) < H_VISIBLE) && (int'(pixel_y) < V_VISIBLE);
    assign frame_start = pix_en && (pixel_x == 11'd0) && (pixel_y == 10'd0);

    assign hsync_c = ((int'(pixel_x) >= H_SYNC_START) && (int'(pixel_x) < H_SYNC_END))
                     ? SYNC_POL : ~SYNC_POL;
    assign vsync_c = ((int'(pixel_y) >= V_SYNC_START) && (int'(pixel_y) < V_SYNC_END))
                     ? SYNC_POL : ~SYNC_POL;

    // pixel_on is only meaningful inside the visible area; blanking is forced black.
    assign rgb_c = video_on ? (pixel_on ? FG_COLOR : BG_COLOR) : 12'h000;

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_x <= 11'd0;
            pixel_y <= 10'd0;
            hsync   <= ~SYNC_POL;
            vsync   <= ~SYNC_POL;
            rgb     <= 12'h000;
        end else if (pix_en) begin
            if (h_last) begin
                pixel_x <= 11'd0;
                pixel_y <= v_last ? 10'd0 : pixel_y + 10'd1;
            end else begin
                pixel_x <= pixel_x + 11'd1;
            end
            hsync <= hsync_c;
            vsync <= vsync_c;
            rgb   <= rgb_c;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen with a raster-index reference model
module tb_vga_timing_gen;

    localparam int          HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int          VV = 10, VF = 2, VS = 3, VB = 2;
    localparam logic        POL = 1'b1;
    localparam logic [11:0] FG = 12'hA5C;
    localparam logic [11:0] BG = 12'h123;
    localparam int          HT = HV + HF + HS + HB;
    localparam int          VT = VV + VF + VS + VB;
    localparam int          FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic        pixel_on = 1'b0;
    logic [10:0] pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(POL), .FG_COLOR(FG), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .pixel_on(pixel_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .frame_start(frame_start), .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference: raster index n counts pix_en cycles since reset, modulo the frame.
    int          n = 0;
    bit          reg_valid = 0;
    logic        exp_hs, exp_vs;
    logic [11:0] exp_rgb;
    int          cyc = 0;
    int          last_fs = -1;
    int          exp_period = 0;

    task automatic check_int(input string tag, input int got, input int want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (n=%0d)", tag, got, want, n);
        end
    endtask

    task automatic check_bits(input string tag, input logic [11:0] got, input logic [11:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (n=%0d)", tag, got, want, n);
        end
    endtask

    // One clock: drive inputs at negedge, check everything, advance model, take the edge.
    task automatic step(input logic r, input logic en, input logic on);
        int x, y;
        bit vis;
        @(negedge clk);
        rst = r; pix_en = en; pixel_on = on;
        #1;
        if (reg_valid) begin
            check_bits("hsync", {11'd0, hsync}, {11'd0, exp_hs});
            check_bits("vsync", {11'd0, vsync}, {11'd0, exp_vs});
            check_bits("rgb", rgb, exp_rgb);
            x = n % HT;
            y = n / HT;
            vis = (x < HV) && (y < VV);
            check_int("pixel_x", int'(pixel_x), x);
            check_int("pixel_y", int'(pixel_y), y);
            check_int("video_on", int'(video_on), int'(vis));
            check_int("frame_start", int'(frame_start), int'(en && n == 0));
            if (frame_start && !r) begin
                if (last_fs >= 0 && exp_period > 0)
                    check_int("frame_period", cyc - last_fs, exp_period);
                last_fs = cyc;
            end
            if (r) begin
                n = 0; exp_hs = ~POL; exp_vs = ~POL; exp_rgb = 12'h000;
            end else if (en) begin
                exp_hs  = (x >= HV + HF && x < HV + HF + HS) ? POL : ~POL;
                exp_vs  = (y >= VV + VF && y < VV + VF + VS) ? POL : ~POL;
                exp_rgb = vis ? (on ? FG : BG) : 12'h000;
                n = (n + 1) % FRAME;
            end
        end else if (r) begin
            n = 0; exp_hs = ~POL; exp_vs = ~POL; exp_rgb = 12'h000;
            reg_valid = 1;
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        int guard;
        // Reset, with pix_en varying to show it is irrelevant during reset.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);

        // Continuous pix_en over more than a frame, random pixel_on.
        exp_period = FRAME; last_fs = -1;
        for (int i = 0; i < FRAME + HT + 5; i++)
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)));

        // Alternating pix_en doubles the frame period in clk cycles.
        exp_period = 2 * FRAME; last_fs = -1;
        for (int i = 0; i < 4 * FRAME + 10; i++)
            step(1'b0, 1'(i % 2 == 0), 1'($urandom_range(0, 1)));

        // Random enables, random data, occasional mid-frame reset.
        exp_period = 0; last_fs = -1;
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)));

        // Directed reset inside the visible area, then resume counting from (0,0).
        guard = 0;
        while (n != 5 * HT + 10 && guard < 2 * FRAME) begin
            step(1'b0, 1'b1, 1'b1);
            guard++;
        end
        check_int("reach_reset_point", n, 5 * HT + 10);
        step(1'b1, 1'b1, 1'b1);
        exp_period = FRAME; last_fs = -1;
        for (int i = 0; i < FRAME + 3; i++)
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, 800, active pixels per line.
REQ-002 Parameter H_FRONT, 56, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 120, hsync pulse width in pixels.
REQ-004 Parameter H_BACK, 64, horizontal back porch in pixels.
REQ-005 Parameter V_VISIBLE, 600, active lines per frame.
REQ-006 Parameter V_FRONT, 37, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 6, vsync pulse width in lines.
REQ-008 Parameter V_BACK, 23, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, 1'b1, active level of hsync/vsync.
REQ-010 Parameter FG_COLOR, 12'hFFF, RGB444 colour for lit pixels; BG_COLOR, 12'h000, colour for unlit visible pixels.
REQ-011 clk  input  1  single clock; all state updates on rising edge.
REQ-012 rst  input  1  synchronous, active-high reset.
REQ-013 pix_en  input  1  pixel-rate enable; counters and output stage advance only on cycles with pix_en=1.
REQ-014 pixel_on  input  1  combinational lit/unlit result from display blocks for the current pixel_x/pixel_y.
REQ-015 pixel_x  output  11  current horizontal count, 0..H_TOTAL-1 (H_TOTAL = sum of H parameters = 1040).
REQ-016 pixel_y  output  10  current vertical count, 0..V_TOTAL-1 (V_TOTAL = sum of V parameters = 666).
REQ-017 video_on  output  1  high when pixel_x < H_VISIBLE and pixel_y < V_VISIBLE (combinational from counters).
REQ-018 frame_start  output  1  high when pix_en=1 and pixel_x=0 and pixel_y=0.
REQ-019 hsync, vsync  output  1 each  registered sync outputs, pipelined to align with rgb.
REQ-020 rgb  output  12  registered RGB444 pixel colour.

Function
REQ-021 pixel_x SHALL increment by 1 on each pix_en cycle and wrap from H_TOTAL-1 to 0.
REQ-022 pixel_y SHALL increment by 1 only on the pix_en cycle where pixel_x wraps, and wrap from V_TOTAL-1 to 0 on that same cycle when at V_TOTAL-1.
REQ-023 With pix_en=0, counters and all registered outputs SHALL hold their values.
REQ-024 Internal hsync_c SHALL be SYNC_POL when H_VISIBLE+H_FRONT <= pixel_x < H_VISIBLE+H_FRONT+H_SYNC (856..975 default), else ~SYNC_POL.
REQ-025 Internal vsync_c SHALL be SYNC_POL when V_VISIBLE+V_FRONT <= pixel_y < V_VISIBLE+V_FRONT+V_SYNC (637..642 default), else ~SYNC_POL.
REQ-026 On each pix_en cycle, the output register SHALL capture hsync<=hsync_c, vsync<=vsync_c, rgb<= (video_on ? (pixel_on ? FG_COLOR : BG_COLOR) : 12'h000).
REQ-027 Latency: hsync/vsync/rgb SHALL reflect the pixel at (pixel_x, pixel_y) exactly one pix_en cycle after those coordinates are presented.
REQ-028 pixel_on SHALL be ignored (rgb = 0) whenever video_on=0, including blanking inside sync pulses.
REQ-029 Frame length SHALL be exactly H_TOTAL*V_TOTAL pix_en cycles (692,640 default); frame_start SHALL pulse once per frame.
REQ-030 Counter widths SHALL not overflow: H_TOTAL <= 2048, V_TOTAL <= 1024 are required parameter limits.

Reset
REQ-031 With rst=1 at a rising edge, independent of pix_en, pixel_x=0, pixel_y=0, hsync=vsync=~SYNC_POL, rgb=12'h000 SHALL hold on the following cycle.
REQ-032 Reset asserted mid-line or mid-frame SHALL abandon the current frame; first pix_en cycle after rst deasserts SHALL present (0,0) with frame_start=1.
REQ-033 rst SHALL take priority over pix_en and counter wrap.

Verification
REQ-034 Reset then pix_en=1 continuously -> cycle 0: pixel_x=0, pixel_y=0, frame_start=1, video_on=1; 800 cycles later video_on=0 (pixel_x=800).
REQ-035 Hold pixel_on=1, pix_en=1 -> rgb=12'hFFF one cycle after pixel_x=0..799 visible; rgb=12'h000 one cycle after pixel_x=800..1039.
REQ-036 Run one line -> hsync=1 registered for pixel_x 856..975 (120 cycles, output seen at 857..976 cycle slots), 0 otherwise; pixel_x wraps 1039->0 with pixel_y 0->1.
REQ-037 Run full frame -> vsync=1 for lines 637..642 (6*1040=6240 cycles); pixel_y wraps 665->0 together with pixel_x 1039->0; next frame_start exactly 692,640 cycles after the previous.
REQ-038 Toggle pix_en 1,0,1,0 -> counters and outputs advance only on pix_en=1 cycles; frame period doubles to 1,385,280 clk cycles.
REQ-039 Assert rst at pixel_x=500, pixel_y=300 for one cycle -> next cycle pixel_x=0, pixel_y=0, hsync=vsync=0, rgb=0; counting resumes from (0,0).
